alarm_bank: RTL
===============

Name: alarm_bank

Overview:
- Multi-channel successor to the single bell comparator: NUM_ALARMS independent BCD alarm settings (hh:mm), each with its own enable bit.
- A shared ring controller adds ring timeout, snooze with a retry limit, and stop.
- Sits beside the timekeeping counters. Consumes their BCD time digits and drives the buzzer.
- Everything runs on one system clock. The 1 Hz tick and the tone sources are synchronous inputs.

Parameters:
- NUM_ALARMS, 4: number of alarm channels (1..16).
- SEL_W, 2: width of the channel select; must satisfy 2^SEL_W >= NUM_ALARMS.
- RING_SEC, 60: seconds of ringing before automatic stop.
- SNOOZE_SEC, 300: seconds spent in snooze before ringing resumes.
- SNOOZE_MAX, 3: snoozes allowed per trigger; the next snooze press acts as stop.
- BELL_IDLE, 1'b1: bell_out level when not ringing (buzzer is active-low).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous active-high reset.
- sec_tick, input, 1: one-cycle pulse, once per second.
- set_sel, input, SEL_W: channel addressed by the set and enable keys.
- set_hr_key, input, 1: level. While high, the selected hour increments on each sec_tick.
- set_min_key, input, 1: level. While high, the selected minute increments on each sec_tick.
- en_toggle, input, 1: one-cycle pulse. Toggles the enable bit of the selected channel.
- snooze_key, input, 1: one-cycle pulse.
- stop_key, input, 1: one-cycle pulse.
- h_cntH, h_cntL, m_cntH, m_cntL, s_cntH, s_cntL, input, 4 each: current time in BCD.
- tone_a, tone_b, input, 1 each: tone waveforms. tone_a is used on odd seconds, tone_b on even seconds.
- bell_out, output, 1: buzzer drive, registered.
- ring_active, output, 1: high in the RINGING state.
- snoozing, output, 1: high in the SNOOZE state.
- ring_idx, output, SEL_W: channel that caused the current ring or snooze.
- alarm_en, output, NUM_ALARMS: enable bits.
- set_hr, output, 8*NUM_ALARMS: per-channel hour in BCD. Channel i occupies bits [8i+7:8i]; the high nibble is tens.
- set_min, output, 8*NUM_ALARMS: per-channel minute in BCD, same packing.

Behaviour:
- Reset:
  - Every set_hr and set_min is 00.
  - alarm_en = 0; state IDLE; ring_idx = 0; all counters 0.
  - bell_out = BELL_IDLE; ring_active = 0; snoozing = 0.
- Setting:
  - Hour counts 00..23 and wraps 23->00. Minute counts 00..59 and wraps 59->00, with no carry into the hour.
  - Both keys may be active at once; hour and minute then both step on the same tick.
  - A set_sel value >= NUM_ALARMS is ignored by the set keys and by en_toggle.
  - Setting updates are visible on set_hr/set_min the cycle after sec_tick.
- Match:
  - match[i] = alarm_en[i] && hh:mm equals channel i && s_cntH:s_cntL == 00.
  - match is registered as match_q.
  - trig[i] = match[i] && !match_q[i]. This is rising-edge only, so a stopped alarm does not re-fire within the same second.
- States: IDLE, RINGING, SNOOZE.
- IDLE:
  - Any trig moves to RINGING on the next cycle.
  - If several channels trigger, the lowest index is captured in ring_idx.
  - ring_sec and snooze_cnt clear.
- RINGING:
  - ring_sec increments on each sec_tick. At ring_sec == RING_SEC-1 plus a sec_tick, go to IDLE.
  - stop_key goes to IDLE.
  - snooze_key:
    - If snooze_cnt < SNOOZE_MAX: go to SNOOZE, increment snooze_cnt, clear the snooze timer.
    - Otherwise: go to IDLE.
  - New trigs are ignored.
- SNOOZE:
  - The snooze timer increments on each sec_tick. At SNOOZE_SEC-1 plus a sec_tick, go to RINGING with ring_sec cleared.
  - stop_key goes to IDLE.
  - A trig on a channel other than ring_idx goes to RINGING for that channel, with snooze_cnt and ring_sec cleared.
- Priority within a cycle: rst > stop_key > snooze_key > timeout > trig.
- Disabling the channel: if en_toggle clears the enable bit of ring_idx while in RINGING or SNOOZE, go to IDLE next cycle.
- Edits: editing the time of the active channel does not affect the state machine.
- bell_out:
  - Registered, one cycle of latency.
  - In RINGING: tone_a when s_cntL[0] = 1, else tone_b.
  - Otherwise: BELL_IDLE.
- Counter widths: sized by $clog2 of their limits. All counters saturate-safe; no wrap beyond their limits.

Test Plan:
- Reset mid-ring: assert rst while RINGING -> bell_out=1, ring_active=0, alarm_en=0, set_hr=0 on the same cycle, asynchronously.
- Set wrap: sel=1, hold set_hr_key for 25 ticks from 00 -> set_hr[15:8]=8'h01. Hold set_min_key for 61 ticks -> 8'h01, with hour unchanged.
- Trigger and timeout:
  - Setup: ch2 = 07:30 enabled; drive time 07:29:59 -> 07:30:00.
  - Expect: ring_active rises one cycle after the match; ring_idx=2.
  - Expect: bell_out follows tone_b at second 00 and tone_a at second 01.
  - Expect: automatic IDLE after 60 ticks.
- Snooze limit: with RING_SEC=60, SNOOZE_SEC=5, SNOOZE_MAX=2:
  - Snooze -> ringing resumes after 5 ticks.
  - Snooze again -> same.
  - Third snooze press -> IDLE.
- Simultaneous trigger: ch0 and ch3 both 12:00 enabled -> ring_idx=0. Stop at 12:00:00 -> no re-ring within that second.
- Disable during snooze: ch1 ringing, press snooze, then en_toggle with sel=1 -> IDLE, snoozing=0, alarm_en[1]=0.

Source files
------------

// File: rtl/alarm_bank.sv
// Multi-channel BCD alarm bank: per-channel hh:mm settings with enables, plus a shared
// ring controller providing ring timeout, limited snooze and stop.
module alarm_bank #(
    parameter int unsigned NUM_ALARMS = 4,
    parameter int unsigned SEL_W      = 2,
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned SNOOZE_SEC = 300,
    parameter int unsigned SNOOZE_MAX = 3,
    parameter logic        BELL_IDLE  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sec_tick,
    input  logic [SEL_W-1:0]        set_sel,
    input  logic                    set_hr_key,
    input  logic                    set_min_key,
    input  logic                    en_toggle,
    input  logic                    snooze_key,
    input  logic                    stop_key,
    input  logic [3:0]              h_cntH,
    input  logic [3:0]              h_cntL,
    input  logic [3:0]              m_cntH,
    input  logic [3:0]              m_cntL,
    input  logic [3:0]              s_cntH,
    input  logic [3:0]              s_cntL,
    input  logic                    tone_a,
    input  logic                    tone_b,
    output logic                    bell_out,
    output logic                    ring_active,
    output logic                    snoozing,
    output logic [SEL_W-1:0]        ring_idx,
    output logic [NUM_ALARMS-1:0]   alarm_en,
    output logic [8*NUM_ALARMS-1:0] set_hr,
    output logic [8*NUM_ALARMS-1:0] set_min
);

    localparam int unsigned RW = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;
    localparam int unsigned TW = (SNOOZE_SEC > 1) ? $clog2(SNOOZE_SEC) : 1;
    localparam int unsigned CW = (SNOOZE_MAX > 0) ? $clog2(SNOOZE_MAX + 1) : 1;

    localparam logic [RW-1:0] RING_LAST   = RW'(RING_SEC - 1);
    localparam logic [TW-1:0] SNOOZE_LAST = TW'(SNOOZE_SEC - 1);
    localparam logic [CW-1:0] SNOOZE_LIM  = CW'(SNOOZE_MAX);

    typedef enum logic [1:0] {
        StIdle,
        StRinging,
        StSnooze
    } state_e;

    logic [7:0]            hr_q  [NUM_ALARMS];
    logic [7:0]            min_q [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] en_q;
    logic [NUM_ALARMS-1:0] match;
    logic [NUM_ALARMS-1:0] match_q;
    logic [NUM_ALARMS-1:0] trig;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [RW-1:0]    ring_sec_q, ring_sec_d;
    logic [TW-1:0]    snz_tmr_q, snz_tmr_d;
    logic [CW-1:0]    snz_cnt_q, snz_cnt_d;
    logic             bell_q;

    logic             sel_ok;
    logic             idx_dis;
    logic             trig_any, other_any;
    logic [SEL_W-1:0] trig_idx, other_idx;

    function automatic logic [7:0] hr_inc(input logic [7:0] v);
        if (v[7:4] >= 4'd2 && v[3:0] >= 4'd3) begin
            return 8'h00;
        end else if (v[3:0] >= 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end else begin
            return {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

    function automatic logic [7:0] min_inc(input logic [7:0] v);
        if (v[7:4] >= 4'd5 && v[3:0] >= 4'd9) begin
            return 8'h00;
        end else if (v[3:0] >= 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end else begin
            return {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

    assign sel_ok = ({1'b0, set_sel} < (SEL_W + 1)'(NUM_ALARMS));

    // Clearing the enable of the channel currently ringing/snoozing drops back to idle.
    assign idx_dis = en_toggle && sel_ok && (set_sel == idx_q) && en_q[idx_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                hr_q[i]  <= 8'h00;
                min_q[i] <= 8'h00;
            end
            en_q <= '0;
        end else if (sel_ok) begin
            if (sec_tick && set_hr_key) begin
                hr_q[set_sel] <= hr_inc(hr_q[set_sel]);
            end
            if (sec_tick && set_min_key) begin
                min_q[set_sel] <= min_inc(min_q[set_sel]);
            end
            if (en_toggle) begin
                en_q[set_sel] <= ~en_q[set_sel];
            end
        end
    end

    always_comb begin
        match     = '0;
        trig      = '0;
        trig_any  = 1'b0;
        other_any = 1'b0;
        trig_idx  = '0;
        other_idx = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            match[i] = en_q[i] && (hr_q[i] == {h_cntH, h_cntL}) &&
                       (min_q[i] == {m_cntH, m_cntL}) && ({s_cntH, s_cntL} == 8'h00);
            trig[i]  = match[i] && !match_q[i];
        end
        // Descending scan so the lowest triggering index wins.
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (trig[i]) begin
                trig_any = 1'b1;
                trig_idx = SEL_W'(i);
            end
            if (trig[i] && (SEL_W'(i) != idx_q)) begin
                other_any = 1'b1;
                other_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        ring_sec_d = ring_sec_q;
        snz_tmr_d  = snz_tmr_q;
        snz_cnt_d  = snz_cnt_q;
        case (state_q)
            StIdle: begin
                ring_sec_d = '0;
                snz_tmr_d  = '0;
                snz_cnt_d  = '0;
                if (trig_any) begin
                    state_d = StRinging;
                    idx_d   = trig_idx;
                end
            end
            StRinging: begin
                if (stop_key || idx_dis) begin
                    state_d = StIdle;
                end else if (snooze_key) begin
                    if (snz_cnt_q < SNOOZE_LIM) begin
                        state_d   = StSnooze;
                        snz_cnt_d = snz_cnt_q + 1'b1;
                        snz_tmr_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (sec_tick) begin
                    if (ring_sec_q >= RING_LAST) begin
                        state_d = StIdle;
                    end else begin
                        ring_sec_d = ring_sec_q + 1'b1;
                    end
                end
            end
            StSnooze: begin
                if (stop_key || idx_dis) begin
                    state_d = StIdle;
                end else if (sec_tick && (snz_tmr_q >= SNOOZE_LAST)) begin
                    state_d    = StRinging;
                    ring_sec_d = '0;
                end else if (other_any) begin
                    state_d    = StRinging;
                    idx_d      = other_idx;
                    snz_cnt_d  = '0;
                    ring_sec_d = '0;
                end else if (sec_tick) begin
                    snz_tmr_d = snz_tmr_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            ring_sec_q <= '0;
            snz_tmr_q  <= '0;
            snz_cnt_q  <= '0;
            match_q    <= '0;
            bell_q     <= BELL_IDLE;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ring_sec_q <= ring_sec_d;
            snz_tmr_q  <= snz_tmr_d;
            snz_cnt_q  <= snz_cnt_d;
            match_q    <= match;
            // Odd seconds sound tone_a, even seconds tone_b.
            bell_q     <= (state_q == StRinging) ? (s_cntL[0] ? tone_a : tone_b) : BELL_IDLE;
        end
    end

    assign bell_out    = bell_q;
    assign ring_active = (state_q == StRinging);
    assign snoozing    = (state_q == StSnooze);
    assign ring_idx    = idx_q;
    assign alarm_en    = en_q;

    for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_pack
        assign set_hr[8*g +: 8]  = hr_q[g];
        assign set_min[8*g +: 8] = min_q[g];
    end

endmodule
